// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: button edge detection, run/pause/lap/clear sequencing and the small_sec prescaler.
// Optional macro BTN_SYNC_EN adds a 2-flop synchronizer on every button ahead of edge detection.
`timescale 1ns/1ps

module stopwatch_ctrl #(
   parameter int TICK_DIV = 10,
   parameter int DIV_W    = 20
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btn_start,
   input  logic       btn_lap,
   input  logic       btn_clear,
   output logic       cnt_tick,
   output logic       cnt_clr,
   output logic       disp_hold,
   output logic [3:0] lap_count,
   output logic [1:0] state_out
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      RUN   = 2'b01,
      PAUSE = 2'b10,
      LAP   = 2'b11
   } state_t;

   typedef struct packed {
      logic clear;
      logic start;
      logic lap;
   } btn_t;

   typedef enum logic [1:0] {
      EV_NONE,
      EV_CLEAR,
      EV_START,
      EV_LAP
   } ev_sel_t;

   localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [3:0]       LAP_MAX    = 4'd15;

   btn_t             btn_raw;
   btn_t             btn_cur;
   btn_t             btn_prev;
   btn_t             ev;
   ev_sel_t          ev_sel;

   state_t           state_q;
   state_t           state_d;
   logic             clr_d;
   logic [3:0]       lap_d;
   logic             running;
   logic [DIV_W-1:0] presc_q;

   assign btn_raw = {btn_clear, btn_start, btn_lap};

`ifdef BTN_SYNC_EN
   btn_t sync_q1;
   btn_t sync_q2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q1 <= '0;
         sync_q2 <= '0;
      end else begin
         sync_q1 <= btn_raw;
         sync_q2 <= sync_q1;
      end
   end

   assign btn_cur = sync_q2;
`else
   assign btn_cur = btn_raw;
`endif

   // NOTE: every register below uses <= so all flops sample the pre-edge values of each other.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         btn_prev <= '0;
      end else begin
         btn_prev <= btn_cur;
      end
   end

   assign ev = btn_cur & ~btn_prev;

   // Only the highest-priority event of a cycle is acted on; the others are dropped.
   always_comb begin
      ev_sel = EV_NONE;
      if (ev.clear) begin
         ev_sel = EV_CLEAR;
      end else if (ev.start) begin
         ev_sel = EV_START;
      end else if (ev.lap) begin
         ev_sel = EV_LAP;
      end
   end

   // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
   always_comb begin
      state_d = state_q;
      clr_d   = 1'b0;
      lap_d   = lap_count;
      unique case (state_q)
         IDLE: begin
            if (ev_sel == EV_START) begin
               state_d = RUN;
            end else if (ev_sel == EV_CLEAR) begin
               clr_d = 1'b1;
               lap_d = 4'd0;
            end
         end
         RUN: begin
            if (ev_sel == EV_START) begin
               state_d = PAUSE;
            end else if (ev_sel == EV_LAP) begin
               state_d = LAP;
               if (lap_count != LAP_MAX) begin
                  lap_d = lap_count + 4'd1;
               end
            end
         end
         LAP: begin
            if (ev_sel == EV_START) begin
               state_d = PAUSE;
            end else if (ev_sel == EV_LAP) begin
               state_d = RUN;
            end
         end
         PAUSE: begin
            if (ev_sel == EV_START) begin
               state_d = RUN;
            end else if (ev_sel == EV_CLEAR) begin
               state_d = IDLE;
               clr_d   = 1'b1;
               lap_d   = 4'd0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_clr   <= 1'b0;
         disp_hold <= 1'b0;
         lap_count <= 4'd0;
      end else begin
         state_q   <= state_d;
         cnt_clr   <= clr_d;
         disp_hold <= (state_d == LAP);
         lap_count <= lap_d;
      end
   end

   assign state_out = state_q;
   assign running   = (state_q == RUN) || (state_q == LAP);

   // Prescaler advances in RUN and LAP alike, so lap transitions keep the tick cadence; PAUSE freezes the phase.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q  <= '0;
         cnt_tick <= 1'b0;
      end else begin
         cnt_tick <= running && (presc_q == PRESC_LAST);
         if ((state_q == IDLE) || clr_d) begin
            presc_q <= '0;
         end else if (running) begin
            presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed vector table, hand-written timing sequences,
// and randomized button traffic compared against a cycle-level behavioural model.
`timescale 1ns/1ps

module tb_stopwatch_ctrl;

   localparam int TICK_DIV = 10;
   localparam int DIV_W    = 20;

   localparam int S_IDLE  = 0;
   localparam int S_RUN   = 1;
   localparam int S_PAUSE = 2;
   localparam int S_LAP   = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       btn_start;
   logic       btn_lap;
   logic       btn_clear;
   logic       cnt_tick;
   logic       cnt_clr;
   logic       disp_hold;
   logic [3:0] lap_count;
   logic [1:0] state_out;

   int tests  = 0;
   int failed = 0;
   int cyc    = 0;
   int run_start = 0;

   stopwatch_ctrl #(
      .TICK_DIV(TICK_DIV),
      .DIV_W   (DIV_W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_start(btn_start),
      .btn_lap  (btn_lap),
      .btn_clear(btn_clear),
      .cnt_tick (cnt_tick),
      .cnt_clr  (cnt_clr),
      .disp_hold(disp_hold),
      .lap_count(lap_count),
      .state_out(state_out)
   );

   always #5 clk = ~clk;

   // Behavioural model: mode, laps taken, and total running cycles since the last return to idle.
   int       m_state;
   int       m_laps;
   int       m_run;
   bit       m_tick;
   bit       m_clr;
   bit [2:0] m_prev;

   task automatic model_reset();
      m_state = S_IDLE;
      m_laps  = 0;
      m_run   = 0;
      m_tick  = 1'b0;
      m_clr   = 1'b0;
      m_prev  = 3'b000;
   endtask

   task automatic model_step(input bit s, input bit l, input bit c);
      bit ec, es, el, running;
      ec = c && !m_prev[2];
      es = s && !m_prev[1];
      el = l && !m_prev[0];
      m_prev = {c, s, l};
      running = (m_state == S_RUN) || (m_state == S_LAP);
      m_tick = running && (((m_run + 1) % TICK_DIV) == 0);
      if (running) m_run = m_run + 1;
      else if (m_state == S_IDLE) m_run = 0;
      m_clr = 1'b0;
      if (ec) begin
         if (m_state == S_IDLE) begin
            m_clr = 1'b1;
         end else if (m_state == S_PAUSE) begin
            m_state = S_IDLE;
            m_clr   = 1'b1;
            m_laps  = 0;
            m_run   = 0;
         end
      end else if (es) begin
         case (m_state)
            S_IDLE, S_PAUSE: m_state = S_RUN;
            default:         m_state = S_PAUSE;
         endcase
      end else if (el) begin
         if (m_state == S_RUN) begin
            m_state = S_LAP;
            m_laps  = (m_laps >= 15) ? 15 : m_laps + 1;
         end else if (m_state == S_LAP) begin
            m_state = S_RUN;
         end
      end
   endtask

   function automatic logic [8:0] model_vec();
      logic [3:0] laps;
      logic [1:0] st;
      laps = m_laps[3:0];
      st   = m_state[1:0];
      return {m_tick, m_clr, (m_state == S_LAP), laps, st};
   endfunction

   function automatic logic [8:0] dut_vec();
      return {cnt_tick, cnt_clr, disp_hold, lap_count, state_out};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Apply buttons for one edge, advance the model, then compare every output against it.
   task automatic cycle(input bit s, input bit l, input bit c);
      btn_start = s;
      btn_lap   = l;
      btn_clear = c;
      @(posedge clk);
      model_step(s, l, c);
      #1;
      cyc++;
      check("model", dut_vec(), model_vec());
   endtask

   task automatic tick_cadence();
      check("tick_cadence", cnt_tick, ((cyc - run_start) % TICK_DIV) == 0);
   endtask

   typedef struct {
      bit         s;
      bit         l;
      bit         c;
      logic [1:0] st;
      bit         clr;
      bit         hold;
      logic [3:0] laps;
      bit         tick;
   } vec_t;

   vec_t vecs[11];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int first;

      vecs[0]  = '{0, 0, 0, 2'b00, 0, 0, 4'd0, 0};
      vecs[1]  = '{0, 0, 1, 2'b00, 1, 0, 4'd0, 0};
      vecs[2]  = '{0, 0, 1, 2'b00, 0, 0, 4'd0, 0};
      vecs[3]  = '{0, 1, 0, 2'b00, 0, 0, 4'd0, 0};
      vecs[4]  = '{1, 0, 0, 2'b01, 0, 0, 4'd0, 0};
      vecs[5]  = '{0, 1, 0, 2'b11, 0, 1, 4'd1, 0};
      vecs[6]  = '{0, 0, 1, 2'b11, 0, 1, 4'd1, 0};
      vecs[7]  = '{0, 1, 0, 2'b01, 0, 0, 4'd1, 0};
      vecs[8]  = '{1, 0, 0, 2'b10, 0, 0, 4'd1, 0};
      vecs[9]  = '{0, 0, 1, 2'b00, 1, 0, 4'd0, 0};
      vecs[10] = '{0, 0, 0, 2'b00, 0, 0, 4'd0, 0};

      reset     = 1'b1;
      btn_start = 1'b0;
      btn_lap   = 1'b0;
      btn_clear = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_outputs", dut_vec(), 9'd0);
      reset = 1'b0;
      model_reset();

      // Directed vector table
      for (int i = 0; i < 11; i++) begin
         cycle(vecs[i].s, vecs[i].l, vecs[i].c);
         check($sformatf("vec%0d", i), dut_vec(),
               {vecs[i].tick, vecs[i].clr, vecs[i].hold, vecs[i].laps, vecs[i].st});
      end

      // Basic run: ticks exactly at +10, +20, +30 after RUN appears
      cycle(1, 0, 0);
      check("run_state", state_out, 2'b01);
      run_start = cyc;
      for (int i = 1; i <= 35; i++) begin
         cycle(0, 0, 0);
         check("basic_tick", cnt_tick, (i % TICK_DIV) == 0);
      end

      // Laps: display freeze, saturation at 15, cadence undisturbed
      for (int k = 1; k <= 17; k++) begin
         cycle(0, 1, 0);
         check("lap_hold", disp_hold, 1'b1);
         check("lap_count", lap_count, (k > 15) ? 15 : k);
         tick_cadence();
         cycle(0, 0, 0);
         tick_cadence();
         cycle(0, 1, 0);
         check("lap_release", disp_hold, 1'b0);
         tick_cadence();
         cycle(0, 0, 0);
         tick_cadence();
      end

      // Clear is ignored while running
      cycle(0, 0, 1);
      check("clear_in_run_clr", cnt_clr, 1'b0);
      check("clear_in_run_state", state_out, 2'b01);
      cycle(0, 0, 0);

      // Pause then clear
      cycle(1, 0, 0);
      check("pause_state", state_out, 2'b10);
      cycle(0, 0, 0);
      cycle(0, 0, 1);
      check("pause_clear", dut_vec(), {1'b0, 1'b1, 1'b0, 4'd0, 2'b00});
      cycle(0, 0, 0);
      check("clr_one_cycle", cnt_clr, 1'b0);

      // Held clear gives one pulse
      n = 0;
      for (int i = 0; i < 20; i++) begin
         cycle(0, 0, 1);
         if (cnt_clr) n++;
      end
      check("clr_hold_pulses", n, 1);
      cycle(0, 0, 0);

      // Pause/resume keeps prescaler phase: pause after 4 running cycles, resume -> tick 6 later
      cycle(1, 0, 0);
      repeat (3) cycle(0, 0, 0);
      cycle(1, 0, 0);
      check("phase_pause_state", state_out, 2'b10);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         cycle(0, 0, 0);
         if (cnt_tick) n++;
      end
      check("no_tick_in_pause", n, 0);
      cycle(1, 0, 0);
      check("resume_state", state_out, 2'b01);
      first = 0;
      for (int j = 1; j <= 30; j++) begin
         cycle(0, 0, 0);
         if (cnt_tick && first == 0) first = j;
      end
      check("resume_phase", first, 6);

      // Simultaneous events
      cycle(1, 1, 0);
      check("start_beats_lap_state", state_out, 2'b10);
      check("start_beats_lap_laps", lap_count, 4'd0);
      cycle(0, 0, 0);
      cycle(1, 0, 1);
      check("clear_beats_start_state", state_out, 2'b00);
      check("clear_beats_start_clr", cnt_clr, 1'b1);
      cycle(0, 0, 0);

      // Asynchronous reset mid-run with prescaler at 7
      cycle(1, 0, 0);
      repeat (7) cycle(0, 0, 0);
      #2;
      reset = 1'b1;
      #1;
      check("async_reset", dut_vec(), 9'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
      n = 0;
      for (int i = 0; i < 15; i++) begin
         cycle(0, 0, 0);
         if (cnt_tick) n++;
      end
      check("post_reset_no_tick", n, 0);
      check("post_reset_state", state_out, 2'b00);
      cycle(1, 0, 0);
      first = 0;
      for (int j = 1; j <= 30; j++) begin
         cycle(0, 0, 0);
         if (cnt_tick && first == 0) first = j;
      end
      check("post_reset_first_tick", first, TICK_DIV);

      // Button held through reset release yields one event on the first edge
      btn_start = 1'b1;
      reset     = 1'b1;
      #10;
      reset = 1'b0;
      model_reset();
      cycle(1, 0, 0);
      check("held_through_reset", state_out, 2'b01);
      cycle(1, 0, 0);
      check("held_single_event", state_out, 2'b01);
      cycle(0, 0, 0);

      // Random traffic against the model
      for (int i = 0; i < 4000; i++) begin
         cycle($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
